// File: rtl/sync_pattern_gen_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sync_pattern_gen_pkg
// Purpose  : Shared definitions for the sync/pattern generator: FSM state
//            encoding, pattern-select codes, 720p60 default timing and the
//            PRBS7 seed.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sync_pattern_gen_pkg;

    // FSM state encoding
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Pattern-select codes
    localparam logic [1:0] PAT_BARS    = 2'd0;
    localparam logic [1:0] PAT_RAMP    = 2'd1;
    localparam logic [1:0] PAT_CHECKER = 2'd2;
    localparam logic [1:0] PAT_PRBS    = 2'd3;

    // 720p60 default timing (clocks per line / lines per frame)
    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_H_FP     = 110;
    localparam int DEF_H_SYNC   = 40;
    localparam int DEF_H_BP     = 220;
    localparam int DEF_V_ACTIVE = 720;
    localparam int DEF_V_FP     = 5;
    localparam int DEF_V_SYNC   = 5;
    localparam int DEF_V_BP     = 20;

    // PRBS7 frame-start seed
    localparam logic [6:0] PRBS_SEED = 7'h7F;

    // Counter width for a given total; at least 8 bits so the ramp byte and
    // the checkerboard bit select are always in range.
    function automatic int cnt_width(input int total);
        int w;
        w = $clog2(total);
        cnt_width = (w < 8) ? 8 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_pattern_gen_lfsr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sync_pattern_gen_lfsr
// Purpose  : PRBS7 generator (x^7 + x^6 + 1). Reloads the seed whenever
//            load_i is high and advances once for every step_i cycle.
//            value_o is the value to present for the current pixel.
// Ports    : rst_n    - synchronous active-low reset
//            HFCLKOUT - clock
//            load_i   - frame start: present the seed this cycle
//            step_i   - active pixel: advance after this cycle
//            value_o  - current 7-bit LFSR value
// Revision : 1.0 - initial release
// ============================================================================
module sync_pattern_gen_lfsr
    import sync_pattern_gen_pkg::*;
(
    input  logic       rst_n,
    input  logic       HFCLKOUT,
    input  logic       load_i,
    input  logic       step_i,
    output logic [6:0] value_o
);

    logic [6:0] lfsr_q;
    logic [6:0] lfsr_d;

    always_comb begin
        // The seed must appear on the very first pixel, so the load bypasses
        // the register rather than waiting a cycle.
        value_o = load_i ? PRBS_SEED : lfsr_q;
        lfsr_d  = step_i ? {value_o[5:0], value_o[6] ^ value_o[5]} : value_o;
    end

    always_ff @(posedge HFCLKOUT) begin
        if (!rst_n) begin
            lfsr_q <= PRBS_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sync_pattern_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sync_pattern_gen
// Purpose  : Video timing generator (default 720p60) with test patterns:
//            colour bars, ramp, checkerboard and optional PRBS7.
//            Build option: define SYNC_PATTERN_GEN_PRBS_EN to include the
//            PRBS7 pattern (code 3); otherwise code 3 outputs 0x00.
// Ports    : rst_n         - synchronous active-low reset
//            HFCLKOUT      - pixel clock
//            en_i          - request pattern output
//            pattern_sel_i - pattern select, sampled at frame start
//            hsync_o       - horizontal sync (active level SYNC_POL)
//            vsync_o       - vertical sync (active level SYNC_POL)
//            de_o          - data enable
//            data_o        - pixel byte, 0x00 outside active video
//            frame_start_o - pulse with the first active pixel of a frame
//            frame_cnt_o   - completed frame count (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module sync_pattern_gen
    import sync_pattern_gen_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic        rst_n,
    input  logic        HFCLKOUT,
    input  logic        en_i,
    input  logic [1:0]  pattern_sel_i,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        de_o,
    output logic [7:0]  data_o,
    output logic        frame_start_o,
    output logic [15:0] frame_cnt_o
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HCW      = cnt_width(H_TOTAL);
    localparam int VCW      = cnt_width(V_TOTAL);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int BAR_W    = (H_ACTIVE / 8 > 0) ? (H_ACTIVE / 8) : 1;

    state_e          state_q,       state_d;
    logic [HCW-1:0]  hcnt_q,        hcnt_d;
    logic [VCW-1:0]  vcnt_q,        vcnt_d;
    logic [1:0]      pat_q,         pat_d;
    logic            hsync_q,       hsync_d;
    logic            vsync_q,       vsync_d;
    logic            de_q,          de_d;
    logic [7:0]      data_q,        data_d;
    logic            frame_start_q, frame_start_d;
    logic [15:0]     frame_cnt_q,   frame_cnt_d;

    logic            running;
    logic            at_origin;
    logic            h_last;
    logic            v_last;
    logic            pix_act;
    logic [1:0]      pat_cur;
    logic [HCW-1:0]  bar_idx;
    logic [2:0]      bar_val;
    logic [7:0]      pix_data;

    // ------------------------------------------------------------------
    // Counter-state decode
    // ------------------------------------------------------------------
    always_comb begin
        running   = (state_q == ST_RUN);
        at_origin = (hcnt_q == '0) && (vcnt_q == '0);
        h_last    = (hcnt_q == HCW'(H_TOTAL - 1));
        v_last    = (vcnt_q == VCW'(V_TOTAL - 1));
        pix_act   = running && (hcnt_q < HCW'(H_ACTIVE)) && (vcnt_q < VCW'(V_ACTIVE));
        // The select is taken at the frame origin and used for that same
        // first pixel, so it bypasses the holding register there.
        pat_cur   = at_origin ? pattern_sel_i : pat_q;
    end

`ifdef SYNC_PATTERN_GEN_PRBS_EN
    logic [6:0] lfsr_val;

    sync_pattern_gen_lfsr u_lfsr (
        .rst_n    (rst_n),
        .HFCLKOUT (HFCLKOUT),
        .load_i   (at_origin),
        .step_i   (pix_act),
        .value_o  (lfsr_val)
    );
`endif

    // ------------------------------------------------------------------
    // Pixel data
    // ------------------------------------------------------------------
    always_comb begin
        bar_idx = hcnt_q / HCW'(BAR_W);
        // Clamp so a width not divisible by 8 still ends on the last bar.
        bar_val = (bar_idx > HCW'(7)) ? 3'd7 : bar_idx[2:0];

        case (pat_cur)
            PAT_BARS:    pix_data = {bar_val, 5'b0_0000};
            PAT_RAMP:    pix_data = hcnt_q[7:0];
            PAT_CHECKER: pix_data = (hcnt_q[4] ^ vcnt_q[4]) ? 8'hFF : 8'h00;
            default: begin
`ifdef SYNC_PATTERN_GEN_PRBS_EN
                pix_data = {1'b0, lfsr_val};
`else
                pix_data = 8'h00;
`endif
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;

        case (state_q)
            ST_IDLE: begin
                hcnt_d = '0;
                vcnt_d = '0;
                if (en_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (h_last) begin
                    hcnt_d = '0;
                    if (v_last) begin
                        vcnt_d = '0;
                        // Leave only at the frame wrap so frames always complete.
                        if (!en_i) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        vcnt_d = vcnt_q + 1'b1;
                    end
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        pat_d   = pat_cur;
        de_d    = pix_act;
        data_d  = pix_act ? pix_data : 8'h00;
        hsync_d = (running && (hcnt_q >= HCW'(HS_START)) && (hcnt_q < HCW'(HS_END)))
                  ? SYNC_POL : ~SYNC_POL;
        // vcnt only moves on the hcnt wrap, so vsync edges track hcnt == 0.
        vsync_d = (running && (vcnt_q >= VCW'(VS_START)) && (vcnt_q < VCW'(VS_END)))
                  ? SYNC_POL : ~SYNC_POL;
        frame_start_d = running && at_origin;
        frame_cnt_d   = frame_cnt_q;
        if (pix_act && (hcnt_q == HCW'(H_ACTIVE - 1)) && (vcnt_q == VCW'(V_ACTIVE - 1))) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge HFCLKOUT) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            pat_q         <= PAT_BARS;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            de_q          <= 1'b0;
            data_q        <= 8'h00;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= 16'd0;
        end else begin
            state_q       <= state_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            pat_q         <= pat_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            data_q        <= data_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign de_o          = de_q;
    assign data_o        = data_q;
    assign frame_start_o = frame_start_q;
    assign frame_cnt_o   = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_pattern_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sync_pattern_gen
// Purpose  : Self-checking bench for sync_pattern_gen using small timing
//            (16+2+2+4 clocks x 4+1+1+1 lines). A reference model pushes the
//            expected output word for every clock into a scoreboard queue;
//            each scenario pops and compares it, plus directed checks.
//            Honours SYNC_PATTERN_GEN_PRBS_EN for pattern 3 expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_pattern_gen;

    localparam int HA = 16, HF = 2, HS = 2, HB = 4;
    localparam int VA = 4,  VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam logic SP = 1'b1;

    logic        rst_n = 1'b0;
    logic        HFCLKOUT = 1'b0;
    logic        en_i = 1'b0;
    logic [1:0]  pattern_sel_i = 2'd0;
    logic        hsync_o, vsync_o, de_o, frame_start_o;
    logic [7:0]  data_o;
    logic [15:0] frame_cnt_o;

    sync_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(SP)
    ) u_dut (
        .rst_n         (rst_n),
        .HFCLKOUT      (HFCLKOUT),
        .en_i          (en_i),
        .pattern_sel_i (pattern_sel_i),
        .hsync_o       (hsync_o),
        .vsync_o       (vsync_o),
        .de_o          (de_o),
        .data_o        (data_o),
        .frame_start_o (frame_start_o),
        .frame_cnt_o   (frame_cnt_o)
    );

    always #5 HFCLKOUT = ~HFCLKOUT;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic [7:0]  data;
        logic [15:0] fcnt;
    } obs_t;

    obs_t sb_q[$];
    obs_t exp_cur;
    obs_t obs;
    obs_t rst_vals;
    int   errors = 0;
    int   checks = 0;

    // Reference model state: linear position within the frame
    bit          m_run  = 1'b0;
    int          m_pos  = 0;
    int          m_pat  = 0;
    logic [6:0]  m_lfsr = 7'h7F;
    logic [15:0] m_fcnt = 16'd0;

    function automatic logic [6:0] prbs_next(input logic [6:0] s);
        return {s[5:0], s[6] ^ s[5]};
    endfunction

    function automatic logic [7:0] ref_pixel(input int pat, input int h, input int v,
                                             input logic [6:0] lf);
        case (pat)
            0: return 8'(32 * (h / (HA / 8)));
            1: return 8'(h % 256);
            2: return ((((h >> 4) ^ (v >> 4)) & 1) != 0) ? 8'hFF : 8'h00;
            default: begin
`ifdef SYNC_PATTERN_GEN_PRBS_EN
                return {1'b0, lf};
`else
                return (lf == lf) ? 8'h00 : 8'h00;
`endif
            end
        endcase
    endfunction

    // Predict what the next clock edge produces from the current inputs.
    function automatic void model_step();
        obs_t e;
        int   h, v;
        bit   act;
        h = m_pos % HT;
        v = m_pos / HT;
        e = '0;
        e.hs = ~SP;
        e.vs = ~SP;
        if (!rst_n) begin
            m_run = 1'b0; m_pos = 0; m_pat = 0; m_fcnt = 16'd0; m_lfsr = 7'h7F;
        end else begin
            if (m_pos == 0) begin
                m_pat  = int'(pattern_sel_i);
                m_lfsr = 7'h7F;
            end
            act  = m_run && (h < HA) && (v < VA);
            e.de = act;
            if (m_run && h >= HA + HF && h < HA + HF + HS) e.hs = SP;
            if (m_run && v >= VA + VF && v < VA + VF + VS) e.vs = SP;
            e.fs = m_run && (m_pos == 0);
            if (act) begin
                e.data = ref_pixel(m_pat, h, v, m_lfsr);
                m_lfsr = prbs_next(m_lfsr);
            end
            if (act && h == HA - 1 && v == VA - 1) m_fcnt = m_fcnt + 16'd1;
            if (m_run) begin
                m_pos = (m_pos + 1) % FRAME;
                if (m_pos == 0 && !en_i) m_run = 1'b0;
            end else if (en_i) begin
                m_run = 1'b1;
            end
        end
        e.fcnt = m_fcnt;
        sb_q.push_back(e);
    endfunction

    // One clock: push expectation, advance to the falling edge, sample.
    task automatic tick();
        model_step();
        @(negedge HFCLKOUT);
        exp_cur = sb_q.pop_front();
        obs = {hsync_o, vsync_o, de_o, frame_start_o, data_o, frame_cnt_o};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en_i = 1'b0; pattern_sel_i = 2'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== rst_vals) begin
                errors++; $display("FAIL reset cyc=%0d got=%h want=%h", i, obs, rst_vals);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs !== exp_cur) begin
                errors++; $display("FAIL idle cyc=%0d got=%h want=%h", i, obs, exp_cur);
            end
        end
    endtask

    task automatic test_ramp();
        int k = 0, n_hs = 0, n_vs = 0, n_fs = 0, last_rise = -1;
        logic prev_hs = ~SP;
        pattern_sel_i = 2'd1; en_i = 1'b1;
        for (int i = 0; i < FRAME + 1; i++) begin
            tick();
            checks++;
            if (obs !== exp_cur) begin
                errors++; $display("FAIL ramp_sb cyc=%0d got=%h want=%h", i, obs, exp_cur);
            end
            if (obs.de === 1'b1) begin
                checks++;
                if (obs.data !== 8'(k % HA)) begin
                    errors++; $display("FAIL ramp_data px=%0d got=%h want=%h", k, obs.data, 8'(k % HA));
                end
                k++;
            end
            if (obs.hs === SP && prev_hs !== SP) begin
                if (last_rise >= 0) begin
                    checks++;
                    if (i - last_rise != HT) begin
                        errors++; $display("FAIL hsync_period got=%0d want=%0d", i - last_rise, HT);
                    end
                end
                last_rise = i;
            end
            prev_hs = obs.hs;
            if (obs.hs === SP) n_hs++;
            if (obs.vs === SP) n_vs++;
            if (obs.fs === 1'b1) n_fs++;
        end
        checks++;
        if (k != HA * VA) begin errors++; $display("FAIL de_count got=%0d want=%0d", k, HA * VA); end
        checks++;
        if (n_hs != HS * VT) begin errors++; $display("FAIL hsync_count got=%0d want=%0d", n_hs, HS * VT); end
        checks++;
        if (n_vs != VS * HT) begin errors++; $display("FAIL vsync_count got=%0d want=%0d", n_vs, VS * HT); end
        checks++;
        if (n_fs != 1) begin errors++; $display("FAIL ramp_fs_count got=%0d want=1", n_fs); end
        checks++;
        if (obs.fcnt !== 16'd1) begin errors++; $display("FAIL ramp_fcnt got=%0d want=1", obs.fcnt); end
    endtask

    task automatic test_bars();
        logic [7:0] bar_tbl [HA];
        int k = 0;
        bar_tbl = '{8'h00, 8'h00, 8'h20, 8'h20, 8'h40, 8'h40, 8'h60, 8'h60,
                    8'h80, 8'h80, 8'hA0, 8'hA0, 8'hC0, 8'hC0, 8'hE0, 8'hE0};
        pattern_sel_i = 2'd0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            checks++;
            if (obs !== exp_cur) begin
                errors++; $display("FAIL bars_sb cyc=%0d got=%h want=%h", i, obs, exp_cur);
            end
            if (obs.de === 1'b1) begin
                checks++;
                if (obs.data !== bar_tbl[k % HA]) begin
                    errors++; $display("FAIL bars_data px=%0d got=%h want=%h", k, obs.data, bar_tbl[k % HA]);
                end
                k++;
            end
        end
    endtask

    task automatic test_pattern_switch();
        logic [7:0] bar_tbl [HA];
        logic [7:0] want;
        int k = 0, n_fs = 0;
        bar_tbl = '{8'h00, 8'h00, 8'h20, 8'h20, 8'h40, 8'h40, 8'h60, 8'h60,
                    8'h80, 8'h80, 8'hA0, 8'hA0, 8'hC0, 8'hC0, 8'hE0, 8'hE0};
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (i == 60) pattern_sel_i = 2'd2;
            tick();
            checks++;
            if (obs !== exp_cur) begin
                errors++; $display("FAIL switch_sb cyc=%0d got=%h want=%h", i, obs, exp_cur);
            end
            if (obs.fs === 1'b1) begin n_fs++; k = 0; end
            if (obs.de === 1'b1) begin
                want = (n_fs >= 2) ? 8'h00 : bar_tbl[k % HA];
                checks++;
                if (obs.data !== want) begin
                    errors++; $display("FAIL switch_data frame=%0d px=%0d got=%h want=%h", n_fs, k, obs.data, want);
                end
                k++;
            end
        end
        checks++;
        if (n_fs != 2) begin errors++; $display("FAIL switch_fs_count got=%0d want=2", n_fs); end
    endtask

    task automatic test_prbs();
        int k = 0, n_fs = 0;
        logic [7:0] first_v, second_v;
`ifdef SYNC_PATTERN_GEN_PRBS_EN
        first_v = 8'h7F; second_v = 8'h7E;
`else
        first_v = 8'h00; second_v = 8'h00;
`endif
        pattern_sel_i = 2'd3;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            checks++;
            if (obs !== exp_cur) begin
                errors++; $display("FAIL prbs_sb cyc=%0d got=%h want=%h", i, obs, exp_cur);
            end
            if (obs.fs === 1'b1) begin n_fs++; k = 0; end
            if (obs.de === 1'b1) begin
                if (k < 2) begin
                    checks++;
                    if (obs.data !== ((k == 0) ? first_v : second_v)) begin
                        errors++; $display("FAIL prbs_start frame=%0d px=%0d got=%h want=%h", n_fs, k, obs.data,
                                           (k == 0) ? first_v : second_v);
                    end
                end
                k++;
            end
        end
        checks++;
        if (n_fs != 2) begin errors++; $display("FAIL prbs_fs_count got=%0d want=2", n_fs); end
    endtask

    task automatic test_en_drop();
        int n_de = 0, n_fs = 0, n_hs = 0;
        pattern_sel_i = 2'd1;
        for (int i = 0; i < FRAME + 82; i++) begin
            if (i == 50) en_i = 1'b0;
            tick();
            checks++;
            if (obs !== exp_cur) begin
                errors++; $display("FAIL endrop_sb cyc=%0d got=%h want=%h", i, obs, exp_cur);
            end
            if (obs.de === 1'b1) n_de++;
            if (obs.fs === 1'b1) n_fs++;
            if (obs.hs === SP) n_hs++;
        end
        checks++;
        if (n_de != HA * VA) begin errors++; $display("FAIL endrop_de got=%0d want=%0d", n_de, HA * VA); end
        checks++;
        if (n_fs != 1) begin errors++; $display("FAIL endrop_fs got=%0d want=1", n_fs); end
        checks++;
        if (n_hs != HS * VT) begin errors++; $display("FAIL endrop_hs got=%0d want=%0d", n_hs, HS * VT); end
        checks++;
        if (obs.fcnt !== 16'd7) begin errors++; $display("FAIL endrop_fcnt got=%0d want=7", obs.fcnt); end
    endtask

    task automatic test_reset_mid();
        bit hit = 1'b0;
        pattern_sel_i = 2'd1; en_i = 1'b1;
        for (int i = 0; i < 400 && !hit; i++) begin
            tick();
            checks++;
            if (obs !== exp_cur) begin
                errors++; $display("FAIL rstmid_sb cyc=%0d got=%h want=%h", i, obs, exp_cur);
            end
            if (m_run && m_pos == 2 * HT + 5) hit = 1'b1;
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL rstmid_reach got=0 want=1"); end
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs !== rst_vals) begin
                errors++; $display("FAIL rstmid_vals cyc=%0d got=%h want=%h", i, obs, rst_vals);
            end
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs !== rst_vals) begin errors++; $display("FAIL rstmid_idle got=%h want=%h", obs, rst_vals); end
        tick();
        checks++;
        if (obs.fs !== 1'b1 || obs.de !== 1'b1 || obs.data !== 8'h00) begin
            errors++; $display("FAIL rstmid_first fs/de/data got=%b/%b/%h want=1/1/00", obs.fs, obs.de, obs.data);
        end
        for (int i = 0; i < FRAME; i++) begin
            tick();
            checks++;
            if (obs !== exp_cur) begin
                errors++; $display("FAIL rstmid_after cyc=%0d got=%h want=%h", i, obs, exp_cur);
            end
        end
    endtask

    initial begin
        rst_vals    = '0;
        rst_vals.hs = ~SP;
        rst_vals.vs = ~SP;
        test_reset();
        test_ramp();
        test_bars();
        test_pattern_switch();
        test_prbs();
        test_en_drop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/sync_pattern_gen.md
SYNC_PATTERN_GEN -- requirements
Module: sync_pattern_gen

Interface
REQ-001 SHALL have parameters H_ACTIVE=1280, H_FP=110, H_SYNC=40, H_BP=220, V_ACTIVE=720, V_FP=5, V_SYNC=5, V_BP=20 (720p60 timing, counts in clocks/lines).
REQ-002 SHALL have parameter SYNC_POL=1: active level of hsync_o/vsync_o.
REQ-003 SHALL have ports, reset first: rst_n in 1, synchronous active-low reset; HFCLKOUT in 1, clock.
REQ-004 en_i in 1: request pattern output; pattern_sel_i in 2: pattern select.
REQ-005 hsync_o out 1, vsync_o out 1, de_o out 1: timing outputs; data_o out 8: pixel byte.
REQ-006 frame_start_o out 1: one-cycle pulse at first active pixel; frame_cnt_o out 16: completed frames.

Function
REQ-007 SHALL keep counters hcnt 0..H_TOTAL-1 and vcnt 0..V_TOTAL-1, with H_TOTAL=sum of H_* and V_TOTAL=sum of V_*; hcnt wraps to 0 and increments vcnt, which wraps to 0 after V_TOTAL-1.
REQ-008 Line order SHALL be active (hcnt<H_ACTIVE), front porch, sync, back porch; frame order SHALL be active lines, front porch, sync lines, back porch.
REQ-009 de_o SHALL be 1 iff hcnt<H_ACTIVE and vcnt<V_ACTIVE in state RUN.
REQ-010 hsync_o SHALL be SYNC_POL iff H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC, in every line including blanking lines.
REQ-011 vsync_o SHALL be SYNC_POL iff vcnt is within the V sync region, and SHALL change only when hcnt==0.
REQ-012 All outputs SHALL be registered with one-cycle latency from the counter state; data_o SHALL be aligned with de_o and SHALL be 0x00 when de_o=0.
REQ-013 SHALL use FSM states IDLE and RUN. IDLE->RUN when en_i=1, starting at hcnt=vcnt=0. RUN->IDLE only at wrap of the last frame cycle when en_i=0, so frames always complete.
REQ-014 In IDLE: counters held at 0, de_o=0, sync outputs inactive (!SYNC_POL).
REQ-015 pattern_sel_i SHALL be sampled only at frame start (hcnt=vcnt=0); a change mid-frame SHALL take effect next frame.
REQ-016 Pattern 0, colour bars: data = 0x20*(hcnt/(H_ACTIVE/8)), giving 0x00..0xE0.
REQ-017 Pattern 1, ramp: data = hcnt[7:0]; the value wraps every 256 pixels.
REQ-018 Pattern 2, checkerboard: data = 0xFF if hcnt[4]^vcnt[4], else 0x00.
REQ-019 Pattern 3 is defined in REQ-025.
REQ-020 frame_start_o SHALL pulse coincident with the first de_o=1 of each frame.
REQ-021 frame_cnt_o SHALL increment at the last active pixel of each frame and wrap 0xFFFF->0.

Reset
REQ-022 rst_n=0 at a clock edge SHALL force state IDLE, counters 0, de_o=0, data_o=0x00, hsync_o=vsync_o=!SYNC_POL, frame_start_o=0, frame_cnt_o=0, sampled pattern=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately; after release with en_i=1, a fresh frame SHALL start at hcnt=vcnt=0.

Configuration
REQ-024 Macro SYNC_PATTERN_GEN_PRBS_EN SHALL compile the PRBS pattern in or out.
REQ-025 With the macro defined, pattern 3 SHALL be PRBS7 (x^7+x^6+1), seeded 0x7F at frame start, advanced once per de_o=1 cycle, data = {1'b0, lfsr}. Without the macro, no LFSR logic SHALL exist and pattern 3 SHALL output 0x00.

Structure
REQ-026 A shared package sync_pattern_gen_pkg SHALL hold the FSM state encoding, the pattern-select codes, and the 720p60 default constants.
REQ-027 One sub-module, sync_pattern_gen_lfsr (PRBS7), SHALL be instantiated only under SYNC_PATTERN_GEN_PRBS_EN.

Verification
REQ-028 Default parameters, en_i=1 -> hsync period 1650 clocks with 40 high; vsync period 1650*750 clocks with 5 lines high; 1280*720 de_o cycles per frame.
REQ-029 Parameters H_ACTIVE=16, H_FP=2, H_SYNC=2, H_BP=4, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, pattern 1 -> data_o per line 0x00..0x0F; pattern 0 -> bar values 0x00,0x00,0x20,0x20,...,0xE0,0xE0.
REQ-030 Same small parameters, en_i dropped mid-frame -> current frame completes, then IDLE; frame_cnt_o increments exactly once.
REQ-031 Change pattern_sel_i 0->2 mid-frame -> bars until the next frame_start_o, checkerboard after.
REQ-032 rst_n=0 at vcnt=2, hcnt=5, then released with en_i=1 -> all outputs at reset values, then the new frame begins with frame_start_o on the first active cycle.
REQ-033 With PRBS enabled, pattern 3 -> first bytes 0x7F, then the LFSR sequence repeating with period 127 and restarting each frame; without the macro -> data_o=0x00 throughout.
